// File: rtl/ysyx_22041207_mdu_ctrl.sv
// RV64M multiply/divide controller: sign handling around a shared unsigned multiplier plus a restoring divider.
// Define YSYX_22041207_MDU_DIVZERO_FAST_EN to bypass the divide loop when the divisor is zero.
module ysyx_22041207_mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic        req_w,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_res,
    output logic        busy,
    output logic        mul_valid,
    input  logic        mul_ready,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_out_valid,
    input  logic [63:0] mul_hi,
    input  logic [63:0] mul_lo
);

    // state     | meaning
    // IDLE      | waiting for a request
    // MUL_ISSUE | waiting for the multiplier to be ready, pulse mul_valid
    // MUL_WAIT  | product in flight
    // MUL_DRAIN | flushed, swallowing the product still in flight
    // DIV_RUN   | one restoring-division step per cycle
    // FIX       | sign correction and result select
    // DONE      | result held until resp_ready
    typedef enum logic [2:0] {
        S_IDLE, S_MUL_ISSUE, S_MUL_WAIT, S_MUL_DRAIN, S_DIV_RUN, S_FIX, S_DONE
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic          w_q;
    logic [63:0]   mag_a, mag_b;
    logic          res_neg, rem_neg, b_zero;
    logic [63:0]   dvd_ext;
    logic [127:0]  prod;
    logic [63:0]   rem, quo;
    logic [5:0]    cnt;

    logic          a_sgn, b_sgn, a_neg, b_neg;
    logic [63:0]   a_ext, b_ext, a_mag, b_mag;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (req_op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'd2:    a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_ext = req_w ? {{32{a_sgn & req_a[31]}}, req_a[31:0]} : req_a;
    assign b_ext = req_w ? {{32{b_sgn & req_b[31]}}, req_b[31:0]} : req_b;
    assign a_neg = a_sgn & a_ext[63];
    assign b_neg = b_sgn & b_ext[63];
    assign a_mag = a_neg ? (64'd0 - a_ext) : a_ext;
    assign b_mag = b_neg ? (64'd0 - b_ext) : b_ext;

    logic [64:0] rem_sh, rem_sub;
    logic        q_bit;

    assign rem_sh  = {rem, quo[63]};
    assign rem_sub = rem_sh - {1'b0, mag_b};
    assign q_bit   = ~rem_sub[64];

    logic [127:0] prod_fix;
    logic [63:0]  quo_fix, rem_fix, sel, res;

    assign prod_fix = res_neg ? (128'd0 - prod) : prod;
    assign quo_fix  = res_neg ? (64'd0 - quo) : quo;
    assign rem_fix  = rem_neg ? (64'd0 - rem) : rem;

    // Divide-by-zero results are forced here so both the looped and the bypass path agree.
    always_comb begin
        sel = 64'd0;
        case (op_q)
            3'd0:             sel = prod_fix[63:0];
            3'd1, 3'd2, 3'd3: sel = prod_fix[127:64];
            3'd4, 3'd5:       sel = b_zero ? {64{1'b1}} : quo_fix;
            default:          sel = b_zero ? dvd_ext : rem_fix;
        endcase
    end

    assign res = w_q ? {{32{sel[31]}}, sel[31:0]} : sel;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    // Combinational so the single pulse lands in the first cycle the multiplier is ready.
    assign mul_valid  = (state == S_MUL_ISSUE) && mul_ready;
    assign mul_a      = mag_a;
    assign mul_b      = mag_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            op_q     <= 3'd0;
            w_q      <= 1'b0;
            mag_a    <= 64'd0;
            mag_b    <= 64'd0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            b_zero   <= 1'b0;
            dvd_ext  <= 64'd0;
            prod     <= 128'd0;
            rem      <= 64'd0;
            quo      <= 64'd0;
            cnt      <= 6'd0;
            resp_res <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!flush && req_valid) begin
                        op_q    <= req_op;
                        w_q     <= req_w;
                        mag_a   <= a_mag;
                        mag_b   <= b_mag;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        dvd_ext <= a_ext;
                        b_zero  <= (b_ext == 64'd0);
                        rem     <= 64'd0;
                        quo     <= req_w ? {a_mag[31:0], 32'd0} : a_mag;
                        cnt     <= req_w ? 6'd31 : 6'd63;
`ifdef YSYX_22041207_MDU_DIVZERO_FAST_EN
                        if (req_op[2])
                            state <= (b_ext == 64'd0) ? S_FIX : S_DIV_RUN;
`else
                        if (req_op[2])
                            state <= S_DIV_RUN;
`endif
                        else
                            state <= S_MUL_ISSUE;
                    end
                end
                S_MUL_ISSUE: begin
                    if (mul_ready)
                        state <= flush ? S_MUL_DRAIN : S_MUL_WAIT;
                    else if (flush)
                        state <= S_IDLE;
                end
                S_MUL_WAIT: begin
                    if (flush) begin
                        state <= mul_out_valid ? S_IDLE : S_MUL_DRAIN;
                    end else if (mul_out_valid) begin
                        prod  <= {mul_hi, mul_lo};
                        state <= S_FIX;
                    end
                end
                S_MUL_DRAIN: begin
                    if (mul_out_valid)
                        state <= S_IDLE;
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= q_bit ? rem_sub[63:0] : rem_sh[63:0];
                        quo <= {quo[62:0], q_bit};
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd0)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        resp_res <= res;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_mdu_ctrl.sv
// Randomized bench for ysyx_22041207_mdu_ctrl against an arithmetic reference model.
module tb_ysyx_22041207_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_w;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_res;
    logic        busy;
    logic        mul_valid;
    logic        mul_ready;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_out_valid;
    logic [63:0] mul_hi;
    logic [63:0] mul_lo;

    ysyx_22041207_mdu_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res),
        .busy(busy),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out_valid(mul_out_valid), .mul_hi(mul_hi), .mul_lo(mul_lo)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Multiplier model: one outstanding product, fixed latency per issue.
    int           mul_lat = 1;
    int           mcnt = 0;
    bit           spur_req = 1'b0;
    logic [127:0] mprod;

    initial begin
        bit issued;
        mul_ready     = 1'b1;
        mul_out_valid = 1'b0;
        mul_hi        = 64'd0;
        mul_lo        = 64'd0;
        forever begin
            @(negedge clk);
            issued = mul_valid;
            mul_out_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mul_out_valid = 1'b1;
                    mul_hi = mprod[127:64];
                    mul_lo = mprod[63:0];
                end
            end
            mul_ready = (mcnt == 0);
            if (issued) begin
                mprod = {64'd0, mul_a} * {64'd0, mul_b};
                mcnt  = mul_lat;
            end else if (spur_req && mcnt == 0 && !mul_out_valid) begin
                mul_out_valid = 1'b1;
                mul_hi = {$urandom, $urandom};
                mul_lo = {$urandom, $urandom};
                spur_req = 1'b0;
            end
        end
    end

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, ua, sb, ub, p;
        logic [31:0]  a32, b32, t32;
        int           sa32, sb32;
        longint       sa64, sb64;
        bit           zero, ovf;
        sa = {{64{a[63]}}, a};
        ua = {64'd0, a};
        sb = {{64{b[63]}}, b};
        ub = {64'd0, b};
        a32 = a[31:0];
        b32 = b[31:0];
        sa32 = a32;
        sb32 = b32;
        sa64 = a;
        sb64 = b;
        zero = w ? (b32 == 32'd0) : (b == 64'd0);
        ovf  = w ? (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (op)
            3'd0: begin
                t32 = a32 * b32;
                return w ? sx(t32) : a * b;
            end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (zero) return {64{1'b1}};
                if (ovf)  return w ? sx(a32) : a;
                if (w) begin t32 = sa32 / sb32; return sx(t32); end
                return sa64 / sb64;
            end
            3'd5: begin
                if (zero) return {64{1'b1}};
                if (w) begin t32 = a32 / b32; return sx(t32); end
                return a / b;
            end
            3'd6: begin
                if (zero) return w ? sx(a32) : a;
                if (ovf)  return 64'd0;
                if (w) begin t32 = sa32 % sb32; return sx(t32); end
                return sa64 % sb64;
            end
            default: begin
                if (zero) return w ? sx(a32) : a;
                if (w) begin t32 = a32 % b32; return sx(t32); end
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic w, input logic [63:0] b);
        bit zero;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        if (!op[2]) return mul_lat + 3;
`ifdef YSYX_22041207_MDU_DIVZERO_FAST_EN
        if (zero) return 2;
`endif
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Call right after a negedge with the controller idle.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat_exp,
                          input int hold, input bit spur);
        int lat;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_w     = w;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        if (spur) spur_req = 1'b1;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("latency", 64'(lat), 64'(lat_exp));
        chk("result", resp_res, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_res", resp_res, exp);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_done", 64'({resp_valid, req_ready}), 64'd1);
        spur_req = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_w      = 1'b0;
        req_a      = 64'd0;
        req_b      = 64'd0;
        resp_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mul_valid", 64'(mul_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_res", resp_res, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        mul_lat = 2;
        run_op(3'd3, 1'b0, {64{1'b1}}, 64'd2, 64'd1, 5, 0, 1'b0);
        mul_lat = 1;
        run_op(3'd0, 1'b0, {64{1'b1}}, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0, 1'b0);

        run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, 1'b0);
        run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, {64{1'b1}}, 66, 0, 1'b0);
        run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 34, 0, 1'b0);
        run_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, {64{1'b1}}, 64'd0, 34, 0, 1'b0);

        run_op(3'd5, 1'b0, 64'd5, 64'd0, {64{1'b1}}, exp_lat(3'd5, 1'b0, 64'd0), 0, 1'b0);
        run_op(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, exp_lat(3'd7, 1'b0, 64'd0), 0, 1'b0);

        run_op(3'd7, 1'b0, 64'd17, 64'd5, 64'd2, 66, 5, 1'b0);

        // Flush while the product is in flight; it lands three cycles later.
        mul_lat = 4;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_w     = 1'b0;
        req_a     = 64'd3;
        req_b     = 64'd9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req_ready", 64'(req_ready), 64'd0);
            chk("drain_resp_valid", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        chk("drain_done_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("drain_no_resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end

        // Reset in the tenth divide cycle.
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_w     = 1'b0;
        req_a     = 64'd1000;
        req_b     = 64'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_mul_valid", 64'(mul_valid), 64'd0);
        chk("mid_rst_resp_res", resp_res, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op = 3'($urandom_range(0, 7));
            w  = (op == 3'd0 || op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = rand_val();
            b  = rand_val();
            mul_lat = $urandom_range(1, 4);
            run_op(op, w, a, b, ref_res(op, w, a, b), exp_lat(op, w, b),
                   $urandom_range(0, 3), op[2] && ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
